// File: rtl/nand_logic_engine.sv
// WIDTH-bit logic unit built only from NAND terms, with accumulator feedback and a DEPTH-entry
// valid/ready result FIFO. Define NAND_PARITY_EN to store and present a per-entry parity bit.
module nand_logic_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [1:0]                 in_op,
    input  logic                       in_acc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_parity,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [WIDTH-1:0]           acc
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LevelW = $clog2(DEPTH + 1);
    localparam logic [LevelW-1:0] FullLevel = LevelW'(DEPTH);

    typedef enum logic [1:0] {
        OpNand = 2'd0,
        OpAnd  = 2'd1,
        OpOr   = 2'd2,
        OpXor  = 2'd3
    } op_e;

    function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return ~(x & y);
    endfunction

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  nand_ab;
    logic [WIDTH-1:0]  result;
    logic              push;
    logic              pop;
    logic              push_en;

    // Operand select and NAND-only operation network.
    always_comb begin
        op_a    = in_acc ? acc_q : in_a;
        nand_ab = nand2(op_a, in_b);
        result  = nand_ab;
        unique case (op_e'(in_op))
            OpNand: result = nand_ab;
            OpAnd:  result = nand2(nand_ab, nand_ab);
            OpOr:   result = nand2(nand2(op_a, op_a), nand2(in_b, in_b));
            OpXor:  result = nand2(nand2(op_a, nand_ab), nand2(in_b, nand_ab));
            default: result = nand_ab;
        endcase
    end

    // Handshakes depend only on registered occupancy, so a pop never frees a full slot early.
    always_comb begin
        in_ready  = (level_q != FullLevel);
        out_valid = (level_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        push_en   = push && !rst;
    end

    always_comb begin
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            acc_d    = result;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign out_data = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign acc      = acc_q;

`ifdef NAND_PARITY_EN
    logic par_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push_en) begin
            par_mem_q[wr_ptr_q] <= ^result;
        end
    end

    assign out_parity = out_valid & par_mem_q[rd_ptr_q];
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_nand_logic_engine.sv
// Scoreboard bench for nand_logic_engine (WIDTH=8, DEPTH=4): expected results are queued on
// accept from a behavioural model and compared with what the FIFO delivers.
module tb_nand_logic_engine;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       in_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_parity;
    logic [2:0] level;
    logic [7:0] acc;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] model_acc;

`ifdef NAND_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    nand_logic_engine #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_parity(out_parity),
        .level     (level),
        .acc       (acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
        case (op)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic use_acc);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = use_acc;
    endtask

    // Records this cycle's handshakes (just before the rising edge), then moves to the next
    // falling edge.
    task automatic tick();
        logic [7:0] a;
        logic [7:0] r;
        if (!rst && in_valid && in_ready) begin
            a = in_acc ? model_acc : in_a;
            r = model_op(a, in_b, in_op);
            model_acc = r;
            exp_q.push_back({ParEn & (^r), r});
        end
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_parity, out_data});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        model_acc = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h5A, 8'hA5, 2'd3, 1'b0);
        tick();
        tick();
        checks++; if (level !== 3'd0) begin failures++;
            $display("FAIL reset_level got=%0d want=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (acc !== 8'h00) begin failures++;
            $display("FAIL reset_acc got=%h want=00", acc); end
        checks++; if (out_parity !== 1'b0) begin failures++;
            $display("FAIL reset_parity got=%b want=0", out_parity); end
        do_reset();
    endtask

    task automatic test_ops();
        logic [7:0] want [4];
        logic [8:0] g;
        logic [8:0] e;
        want[0] = 8'h3F; want[1] = 8'hC0; want[2] = 8'hFC; want[3] = 8'h3C;
        do_reset();
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL ops_idle_valid got=%b want=0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hF0, 8'hCC, 2'(i), 1'b0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin failures++;
                $display("FAIL ops_head%0d got=%b/%h want=1/%h", i, out_valid, out_data, want[i]);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        tick();
        checks++; if (acc !== 8'h3C) begin failures++;
            $display("FAIL ops_acc got=%h want=3c", acc); end
        checks++; if (got_q.size() != 4) begin failures++;
            $display("FAIL ops_count got=%0d want=4", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++;
                $display("FAIL ops_extra got=%h want=none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL ops_data got=%h want=%h", g, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL ops_missing got=%0d want=0 left", exp_q.size()); end
    endtask

    task automatic test_accumulator();
        logic [7:0] want [3];
        logic [8:0] g;
        logic [8:0] e;
        want[0] = 8'h01; want[1] = 8'h03; want[2] = 8'h07;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hAA, 8'(1 << i), 2'd3, 1'b1);
            tick();
            checks++; if (out_data !== want[i]) begin failures++;
                $display("FAIL acc_step%0d got=%h want=%h", i, out_data, want[i]); end
        end
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        tick();
        checks++; if (acc !== 8'h07) begin failures++;
            $display("FAIL acc_final got=%h want=07", acc); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++;
                $display("FAIL acc_extra got=%h want=none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL acc_data got=%h want=%h", g, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL acc_missing got=%0d want=0 left", exp_q.size()); end
    endtask

    task automatic test_fill();
        logic [8:0] g;
        logic [8:0] e;
        int n;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'h10 + 8'(k), 8'hFF, 2'd1, 1'b0);
            tick();
        end
        drive(1'b1, 8'h14, 8'hFF, 2'd1, 1'b0);
        checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin failures++;
            $display("FAIL fill_full got=%0d/%b want=4/0", level, in_ready); end
        tick();
        checks++; if (level !== 3'd4) begin failures++;
            $display("FAIL fill_hold got=%0d want=4", level); end
        out_ready = 1'b1;
        tick();
        checks++; if (level !== 3'd3 || in_ready !== 1'b1) begin failures++;
            $display("FAIL fill_reopen got=%0d/%b want=3/1", level, in_ready); end
        tick();
        checks++; if (level !== 3'd3) begin failures++;
            $display("FAIL fill_fifth got=%0d want=3", level); end
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 10 && out_valid; i++) tick();
        n = got_q.size();
        checks++; if (n != 5) begin failures++;
            $display("FAIL fill_count got=%0d want=5", n); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++;
                $display("FAIL fill_extra got=%h want=none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL fill_order got=%h want=%h", g, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL fill_missing got=%0d want=0 left", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] g;
        logic [8:0] e;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'h81, 8'h7E, 2'd2, 1'b0);
        tick();
        drive(1'b1, 8'h96, 8'h0F, 2'd3, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(3)),
                  1'($urandom_range(1)));
            tick();
            checks++; if (level !== 3'd2) begin failures++;
                $display("FAIL b2b_level%0d got=%0d want=2", i, level); end
        end
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 10 && out_valid; i++) tick();
        checks++; if (got_q.size() != 12) begin failures++;
            $display("FAIL b2b_count got=%0d want=12", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++;
                $display("FAIL b2b_extra got=%h want=none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL b2b_order got=%h want=%h", g, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL b2b_missing got=%0d want=0 left", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h33, 8'h55, 2'(k), 1'b0);
            tick();
        end
        checks++; if (level !== 3'd3) begin failures++;
            $display("FAIL mid_pre_level got=%0d want=3", level); end
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'hFF, 8'hFF, 2'd1, 1'b0);
        tick();
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || acc !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got=%0d/%b/%h/%b want=0/0/00/1", level, out_valid, acc,
                     in_ready);
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        exp_q.delete();
        got_q.delete();
        model_acc = 8'h00;
        tick();
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin failures++;
            $display("FAIL mid_after got=%0d/%b want=0/0", level, out_valid); end
    endtask

    task automatic test_parity();
        logic [8:0] g;
        logic [8:0] e;
        do_reset();
        out_ready = 1'b0;
        checks++; if (out_parity !== 1'b0) begin failures++;
            $display("FAIL par_empty got=%b want=0", out_parity); end
        drive(1'b1, 8'hF0, 8'hCC, 2'd0, 1'b0);
        tick();
        drive(1'b1, 8'h07, 8'hFF, 2'd1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        checks++; if (out_data !== 8'h3F || out_parity !== 1'b0) begin failures++;
            $display("FAIL par_nand got=%h/%b want=3f/0", out_data, out_parity); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 8'h07 || out_parity !== ParEn) begin failures++;
            $display("FAIL par_and got=%h/%b want=07/%b", out_data, out_parity, ParEn); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_parity !== 1'b0) begin failures++;
            $display("FAIL par_drained got=%b/%b want=0/0", out_valid, out_parity); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin failures++;
                $display("FAIL par_extra got=%h want=none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL par_data got=%h want=%h", g, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++;
            $display("FAIL par_missing got=%0d want=0 left", exp_q.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        model_acc = 8'h00;
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        test_reset();
        test_ops();
        test_accumulator();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
